// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order imem requests, buffers returned words with their PCs; grant N -> head valid N+2.
// Requests stall once buffered + in-flight reaches DEPTH; a redirect flushes the buffer and drops stale responses.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_pc;
  logic          fetch_fire;
  logic          rsp_live;
  logic          push;
  logic          pop;
  logic          has_head;
  logic          unused_redirect_bits;

  assign redirect_pc          = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc_i[1:0];

  // Every in-flight request already owns a FIFO slot, so a push can never overflow.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_o  = rst_i & ~redirect_i & (credit_used < DEPTH_W);
  assign imem_addr_o = fetch_pc;
  assign fetch_fire  = imem_req_o & imem_gnt_i;

  assign rsp_live = imem_rvalid_i & (outstanding != '0);
  assign push     = rst_i & ~redirect_i & rsp_live & (discard == '0);

  assign has_head      = rst_i & (fifo_count != '0);
  assign instr_valid_o = has_head & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;
  assign instr_o       = has_head ? mem_instr[rd_ptr] : 32'h0;
  assign instr_pc_o    = has_head ? mem_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_i) begin
      // Whatever is still in flight after this edge belongs to the old stream.
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= outstanding - CW'(rsp_live);
      discard     <= outstanding - CW'(rsp_live);
    end else begin
      if (fetch_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(fetch_fire) - CW'(rsp_live);
      if (rsp_live && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (push) begin
        wr_ptr  <= wr_ptr + PW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_rdata_i;
      mem_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory with random grant/latency, stream-based reference model.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  always #5 clk_i = ~clk_i;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  typedef struct packed { logic [31:0] addr; int due; int stream; } req_t;

  req_t        mq[$];
  logic [31:0] grant_log[$];
  logic [31:0] pop_log[$];
  int          cyc, last_due, cur_stream, buffered;
  logic [31:0] exp_fetch_pc, exp_pop_pc;
  int          n_checks, n_fail;
  logic        rst_drive, redir_now;
  logic [31:0] redir_target;
  int          gnt_pct, rdy_pct, lat_min, lat_max;
  logic        saw_grant, saw_pop, saw_rsp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  // One clock: drive at posedge+1, sample and score at posedge+4.
  task automatic cycle();
    req_t e;
    logic exp_req, exp_valid, popped;
    int   d;
    e = '0;
    @(posedge clk_i); #1;
    cyc++;
    rst_i         = rst_drive;
    redirect_i    = redir_now;
    redirect_pc_i = redir_target;
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    instr_ready_i = ($urandom_range(99) < rdy_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mq[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #3;
    exp_req   = rst_i && !redirect_i && (buffered + int'(mq.size()) < DEPTH);
    exp_valid = rst_i && !redirect_i && (buffered > 0);
    n_checks++;
    if (imem_req_o !== exp_req) begin
      n_fail++; $display("FAIL req cyc=%0d: got %b expected %b", cyc, imem_req_o, exp_req);
    end
    if (exp_req) begin
      n_checks++;
      if (imem_addr_o !== exp_fetch_pc) begin
        n_fail++; $display("FAIL addr cyc=%0d: got %h expected %h", cyc, imem_addr_o, exp_fetch_pc);
      end
    end
    n_checks++;
    if (instr_valid_o !== exp_valid) begin
      n_fail++; $display("FAIL valid cyc=%0d: got %b expected %b", cyc, instr_valid_o, exp_valid);
    end
    if (!rst_i || buffered == 0) begin
      n_checks++;
      if (instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin
        n_fail++; $display("FAIL empty_head cyc=%0d: got %h/%h expected 0/0", cyc, instr_o, instr_pc_o);
      end
    end
    popped = exp_valid && instr_ready_i;
    if (popped) begin
      n_checks++;
      if (instr_pc_o !== exp_pop_pc || instr_o !== mem_word(exp_pop_pc)) begin
        n_fail++; $display("FAIL head cyc=%0d: got pc %h word %h expected pc %h word %h",
                           cyc, instr_pc_o, instr_o, exp_pop_pc, mem_word(exp_pop_pc));
      end
    end
    saw_grant = (imem_req_o === 1'b1) && imem_gnt_i;
    saw_pop   = (instr_valid_o === 1'b1) && instr_ready_i;
    saw_rsp   = imem_rvalid_i;
    if (imem_rvalid_i) e = mq.pop_front();
    if (!rst_i) begin
      cur_stream++; buffered = 0; exp_fetch_pc = RESET_PC; exp_pop_pc = RESET_PC;
    end else if (redirect_i) begin
      cur_stream++; buffered = 0;
      exp_fetch_pc = {redir_target[31:2], 2'b00};
      exp_pop_pc   = {redir_target[31:2], 2'b00};
    end else begin
      if (saw_grant) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{addr: imem_addr_o, due: d, stream: cur_stream});
        grant_log.push_back(imem_addr_o);
        exp_fetch_pc += 32'd4;
      end
      if (imem_rvalid_i && e.stream == cur_stream) buffered++;
      if (popped) begin
        buffered--;
        pop_log.push_back(instr_pc_o);
        exp_pop_pc += 32'd4;
      end
    end
  endtask

  // Holds reset at least n cycles and until the memory has returned everything still in flight.
  task automatic do_reset(input int n);
    int k;
    k = 0;
    rst_drive = 1'b0;
    while ((k < n || mq.size() > 0) && k < 60) begin
      cycle();
      k++;
    end
    n_checks++;
    if (mq.size() != 0) begin
      n_fail++; $display("FAIL reset_drain: got %0d pending responses expected 0", mq.size());
    end
    rst_drive = 1'b1;
  endtask

  task automatic test_reset();
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    rst_drive = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin
        n_fail++; $display("FAIL reset_outputs: got req %b valid %b instr %h pc %h expected all 0",
                           imem_req_o, instr_valid_o, instr_o, instr_pc_o);
      end
    end
    rst_drive = 1'b1;
    cycle();
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      n_fail++; $display("FAIL reset_first_fetch: got req %b addr %h expected 1 %h", imem_req_o, imem_addr_o, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int first_grant, first_valid, pops;
    do_reset(2);
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    first_grant = -1; first_valid = -1; pops = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (saw_grant && first_grant < 0) first_grant = cyc;
      if (instr_valid_o === 1'b1 && first_valid < 0) first_valid = cyc;
      if (i >= 12 && saw_pop) pops++;
    end
    n_checks++;
    if (first_grant < 0 || first_valid - first_grant != 2) begin
      n_fail++; $display("FAIL first_latency: got %0d cycles expected 2", first_valid - first_grant);
    end
    n_checks++;
    if (pops != 12) begin
      n_fail++; $display("FAIL throughput: got %0d pops in 12 cycles expected 12", pops);
    end
  endtask

  task automatic test_backpressure();
    int grants;
    logic [31:0] exp_pcs [4];
    exp_pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset(2);
    gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (saw_grant) grants++;
    end
    n_checks++;
    if (grants != DEPTH || int'(dut.fifo_count) != DEPTH || imem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL full_stall: got %0d grants count %0d req %b expected %0d %0d 0",
                         grants, dut.fifo_count, imem_req_o, DEPTH, DEPTH);
    end
    pop_log.delete();
    rdy_pct = 100;
    cycle();
    n_checks++;
    if (!saw_pop || instr_pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL first_pop: got pop %b pc %h req %b expected 1 0 0", saw_pop, instr_pc_o, imem_req_o);
    end
    cycle();
    n_checks++;
    if (imem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL reissue: got req %b expected 1", imem_req_o);
    end
    repeat (3) cycle();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pop_log.size() <= i || pop_log[i] !== exp_pcs[i]) begin
        n_fail++; $display("FAIL drain_order[%0d]: got %h expected %h", i,
                           (pop_log.size() > i) ? pop_log[i] : 32'hX, exp_pcs[i]);
      end
    end
  endtask

  task automatic test_redirect();
    int k;
    do_reset(2);
    gnt_pct = 100; rdy_pct = 100; lat_min = 3; lat_max = 3;
    cycle(); cycle();
    redir_target = 32'h0000_0103; redir_now = 1'b1;
    cycle();
    redir_now = 1'b0;
    n_checks++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL redirect_cycle: got req %b valid %b expected 0 0", imem_req_o, instr_valid_o);
    end
    pop_log.delete();
    k = 0;
    while (pop_log.size() == 0 && k < 30) begin
      cycle();
      k++;
    end
    n_checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h100 || instr_o !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL redirect_target: got pc %h word %h expected pc 100 word %h",
                         instr_pc_o, instr_o, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_collide();
    int k, exp_disc;
    do_reset(2);
    gnt_pct = 100; rdy_pct = 0; lat_min = 2; lat_max = 2;
    k = 0;
    while (!(buffered > 0 && mq.size() > 1 && mq[0].due == cyc + 1) && k < 20) begin
      cycle();
      k++;
    end
    rdy_pct = 100; redir_target = 32'h40; redir_now = 1'b1;
    cycle();
    redir_now = 1'b0;
    n_checks++;
    if (!saw_rsp || instr_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL collide_valid: got rsp %b valid %b expected 1 0", saw_rsp, instr_valid_o);
    end
    exp_disc = mq.size();
    cycle();
    n_checks++;
    if (int'(dut.fifo_count) != 0 || int'(dut.discard) != exp_disc || instr_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL collide_flush: got count %0d discard %0d valid %b expected 0 %0d 0",
                         dut.fifo_count, dut.discard, instr_valid_o, exp_disc);
    end
    repeat (10) cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pcs [3];
    exp_pcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset(2);
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    redir_target = 32'hFFFF_FFF8; redir_now = 1'b1;
    cycle();
    redir_now = 1'b0;
    grant_log.delete(); pop_log.delete();
    repeat (8) cycle();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (grant_log.size() <= i || pop_log.size() <= i ||
          grant_log[i] !== exp_pcs[i] || pop_log[i] !== exp_pcs[i]) begin
        n_fail++; $display("FAIL wrap[%0d]: got addr %h pc %h expected %h", i,
                           (grant_log.size() > i) ? grant_log[i] : 32'hX,
                           (pop_log.size() > i) ? pop_log[i] : 32'hX, exp_pcs[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    int k;
    do_reset(2);
    gnt_pct = 100; rdy_pct = 0; lat_min = 3; lat_max = 3;
    k = 0;
    while (!(buffered >= 2 && mq.size() >= 1) && k < 30) begin
      cycle();
      k++;
    end
    rst_drive = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL midreset_outputs: got req %b valid %b expected 0 0", imem_req_o, instr_valid_o);
      end
    end
    do_reset(2);
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    pop_log.delete();
    k = 0;
    while (pop_log.size() == 0 && k < 20) begin
      cycle();
      k++;
    end
    n_checks++;
    if (pop_log.size() == 0 || pop_log[0] !== RESET_PC || instr_o !== mem_word(RESET_PC)) begin
      n_fail++; $display("FAIL midreset_restart: got pc %h word %h expected pc %h word %h",
                         instr_pc_o, instr_o, RESET_PC, mem_word(RESET_PC));
    end
  endtask

  task automatic test_random();
    int pops;
    do_reset(2);
    lat_min = 1; lat_max = 4; pops = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = int'($urandom_range(100, 20));
        rdy_pct = int'($urandom_range(100, 20));
      end
      redir_now = ($urandom_range(99) < 4);
      redir_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cycle();
      if (saw_pop) pops++;
    end
    redir_now = 1'b0;
    n_checks++;
    if (pops < 200) begin
      n_fail++; $display("FAIL random_progress: got %0d pops expected at least 200", pops);
    end
  endtask

  initial begin
    rst_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    rst_drive = 1'b0; redir_now = 1'b0; redir_target = 32'h0;
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    cyc = 0; last_due = 0; cur_stream = 0; buffered = 0;
    exp_fetch_pc = RESET_PC; exp_pop_pc = RESET_PC;
    n_checks = 0; n_fail = 0;
    saw_grant = 1'b0; saw_pop = 1'b0; saw_rsp = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_midstream_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
